encoder_4to2_serial: RTL

//  Sequential 4-to-2 encoder. It accepts a 4-bit request vector and emits the 2-bit index of every set bit,
//  one index per handshake, in priority order. It is the inverse of decoder_2to4: a decoder output vector
//  (or an OR of several) fed here returns the original index stream.

---
 rtl/encoder_4to2_serial.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/encoder_4to2_serial.sv
// ---------------------------------------------------------------------------
// encoder_4to2_serial
//
// Sequential 4-to-2 encoder. A 4-bit request vector is accepted on a
// valid/ready handshake and the 2-bit index of every set bit is emitted, one
// index per output transfer, in priority order. It is the inverse of
// decoder_2to4: feeding it a decoder output vector (or an OR of several)
// returns the original index stream.
//
// Parameters
//   PRIO_HIGH  0: lowest set bit emitted first, 1: highest set bit first
//
// Ports
//   clk        in   1  clock, all state updates on posedge
//   rst        in   1  synchronous reset, active-high
//   in         in   4  request vector, bit n set = index n pending
//   in_valid   in   1  in is valid this cycle
//   in_ready   out  1  block accepts in this cycle (combinational)
//   out        out  2  index of the current pending bit (registered)
//   out_valid  out  1  out is valid (registered)
//   out_ready  in   1  consumer takes out this cycle
//   out_last   out  1  out is the final index of the vector (registered)
//   err        out  1  only with ENC_ERR_EN: one-cycle pulse after an
//                      all-zero vector has been accepted
//
// Configuration macro
//   ENC_ERR_EN  when defined, adds the err output. When undefined, all-zero
//               vectors are dropped silently.
// ---------------------------------------------------------------------------
module encoder_4to2_serial #(
  parameter int PRIO_HIGH = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last
`ifdef ENC_ERR_EN
  ,
  output logic       err
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t     state;
  logic [3:0] pend;

  logic       transfer;
  logic       accept;
  logic       load;
  logic [3:0] pend_rem;

  // Index of the bit that goes out first for vector v.
  function automatic logic [1:0] enc_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'b00;
    if (PRIO_HIGH != 0) begin
      // Ascending scan: the last hit is the highest set bit.
      for (int i = 0; i < 4; i++) begin
        if (v[i]) idx = 2'(i);
      end
    end else begin
      // Descending scan: the last hit is the lowest set bit.
      for (int i = 3; i >= 0; i--) begin
        if (v[i]) idx = 2'(i);
      end
    end
    return idx;
  endfunction

  // True when exactly one bit of v is set.
  function automatic logic is_single(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  assign transfer = out_valid & out_ready;

  // A new vector is taken while idle, or in the same cycle the final index of
  // the current vector leaves, which gives zero-bubble back-to-back vectors.
  assign in_ready = ~rst & ((state == IDLE) | (transfer & out_last));
  assign accept   = in_valid & in_ready;
  assign load     = accept & (in != 4'b0000);

  // out always holds enc_idx(pend) in EMIT, so it names the bit to retire.
  assign pend_rem = pend & ~(4'b0001 << out);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pend      <= 4'b0000;
      out       <= 2'b00;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
`ifdef ENC_ERR_EN
      err       <= 1'b0;
`endif
    end else begin
`ifdef ENC_ERR_EN
      err <= accept & (in == 4'b0000);
`endif
      case (state)
        IDLE: begin
          if (load) begin
            state     <= EMIT;
            pend      <= in;
            out       <= enc_idx(in);
            out_last  <= is_single(in);
            out_valid <= 1'b1;
          end
        end
        EMIT: begin
          // Without a transfer everything holds, so out is stable under stall.
          if (transfer) begin
            if (out_last) begin
              if (load) begin
                pend     <= in;
                out      <= enc_idx(in);
                out_last <= is_single(in);
              end else begin
                state     <= IDLE;
                pend      <= 4'b0000;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
              end
            end else begin
              pend     <= pend_rem;
              out      <= enc_idx(pend_rem);
              out_last <= is_single(pend_rem);
            end
          end
        end
        default: begin
          state     <= IDLE;
          pend      <= 4'b0000;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule
